// File: rtl/job_launcher.sv
// Start/done worker requester: launches a batch of jobs and streams tagged results.
// Optional per-job WAIT timeout is enabled with `define JOB_LAUNCHER_TIMEOUT_EN.
module job_launcher #(
  parameter int JOB_W       = 8,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic             go_in,
  input  logic [JOB_W-1:0] num_jobs_in,
  input  logic             done_in,
  input  logic [11:0]      pixel_in,
  output logic             start_out,
  output logic             result_valid_out,
  input  logic             result_ready_in,
  output logic [11:0]      result_pixel_out,
  output logic [JOB_W-1:0] result_idx_out,
  output logic             busy_out,
  output logic             batch_done_out,
  output logic             timeout_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_PRESENT,
    S_FINISH
  } state_t;

  state_t           state;
  logic [JOB_W-1:0] num_q;
  logic [JOB_W-1:0] idx_q;

`ifdef JOB_LAUNCHER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wait_cnt;
  logic          tmo_hit;
  assign tmo_hit = (wait_cnt == CW'(TIMEOUT_CYC - 1));
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state            <= S_IDLE;
      num_q            <= '0;
      idx_q            <= '0;
      start_out        <= 1'b0;
      result_valid_out <= 1'b0;
      result_pixel_out <= '0;
      result_idx_out   <= '0;
      busy_out         <= 1'b0;
      batch_done_out   <= 1'b0;
      timeout_out      <= 1'b0;
`ifdef JOB_LAUNCHER_TIMEOUT_EN
      wait_cnt         <= '0;
`endif
    end else begin
      start_out      <= 1'b0;
      batch_done_out <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (go_in) begin
            num_q       <= num_jobs_in;
            idx_q       <= '0;
            timeout_out <= 1'b0;
            busy_out    <= 1'b1;
            if (num_jobs_in == '0) begin
              state          <= S_FINISH;
              batch_done_out <= 1'b1;
            end else begin
              state     <= S_LAUNCH;
              start_out <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          // done_in here is still the previous job's level
          state <= S_WAIT;
`ifdef JOB_LAUNCHER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (done_in) begin
            result_pixel_out <= pixel_in;
            result_idx_out   <= idx_q;
            result_valid_out <= 1'b1;
            state            <= S_PRESENT;
          end
`ifdef JOB_LAUNCHER_TIMEOUT_EN
          else if (tmo_hit) begin
            result_pixel_out <= 12'h000;
            result_idx_out   <= idx_q;
            result_valid_out <= 1'b1;
            timeout_out      <= 1'b1;
            state            <= S_PRESENT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
`endif
        end
        S_PRESENT: begin
          if (result_ready_in) begin
            result_valid_out <= 1'b0;
            if (idx_q == num_q - JOB_W'(1)) begin
              state          <= S_FINISH;
              batch_done_out <= 1'b1;
            end else begin
              idx_q     <= idx_q + JOB_W'(1);
              state     <= S_LAUNCH;
              start_out <= 1'b1;
            end
          end
        end
        S_FINISH: begin
          busy_out <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
